// File: rtl/core_ctrl.sv
// Multi-cycle sequencer: fetch handshake, instruction register, PC and
// retire counter, with Moore-decoded register-file and dmem strobes.
module core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        rf_wr_en_o,
  output logic        load_en_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_rvalid_i,
  output logic [31:0] retire_cnt_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT_I = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;

  logic [6:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       is_alu;
  logic       rd_nz;

  assign opcode   = instr_q[6:0];
  assign is_load  = (opcode == OP_LD);
  assign is_store = (opcode == OP_ST);
  assign is_alu   = (opcode == OP_R) || (opcode == OP_I);
  assign rd_nz    = (instr_q[11:7] != 5'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      cnt_q     <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    unique case (state_q)
      FETCH: state_d = WAIT_I;
      WAIT_I: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_alu || is_load || is_store) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      EXEC: state_d = (is_load || is_store) ? MEM : WB;
      MEM: begin
        if (dmem_rvalid_i) begin
          if (is_store) begin
            pc_d    = pc_q + 32'd4;
            cnt_d   = cnt_q + 32'd1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        pc_d    = pc_q + 32'd4;
        cnt_d   = cnt_q + 32'd1;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // strobes are gated by reset so an in-flight request drops immediately
  assign imem_req_o   = ~rst_i & (state_q == FETCH);
  assign dmem_req_o   = ~rst_i & (state_q == MEM);
  assign dmem_we_o    = ~rst_i & (state_q == MEM) & is_store;
  assign rf_wr_en_o   = ~rst_i & (state_q == WB) & rd_nz;
  assign load_en_o    = ~rst_i & is_load
                        & ((state_q == WB) || (state_q == MEM));
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign instr_o      = instr_q;
  assign retire_cnt_o = cnt_q;
  assign illegal_o    = illegal_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: per-cycle strobe/state traces
// for each instruction class, halt, PC wrap and reset mid-access.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr, instr_w;
  logic [31:0] pc, pc_w;
  logic        rf_wr_en, rf_wr_en_w;
  logic        load_en, load_en_w;
  logic        dmem_req, dmem_req_w;
  logic        dmem_we, dmem_we_w;
  logic        dmem_rvalid;
  logic [31:0] retire, retire_w;
  logic        illegal, illegal_w;
  logic [2:0]  state, state_w;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] imem_word = 32'h0000_0013;
  int dlat = 1;
  int dcnt = 0;

  always #5 clk = ~clk;

  core_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .pc_o(pc),
    .rf_wr_en_o(rf_wr_en), .load_en_o(load_en),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_rvalid_i(dmem_rvalid),
    .retire_cnt_o(retire), .illegal_o(illegal), .state_o(state)
  );

  core_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_w), .imem_addr_o(imem_addr_w),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_o(instr_w), .pc_o(pc_w),
    .rf_wr_en_o(rf_wr_en_w), .load_en_o(load_en_w),
    .dmem_req_o(dmem_req_w), .dmem_we_o(dmem_we_w),
    .dmem_rvalid_i(dmem_rvalid),
    .retire_cnt_o(retire_w), .illegal_o(illegal_w), .state_o(state_w)
  );

  // imem answers one cycle after req; dmem answers on the dlat-th req cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
      dcnt        <= 0;
    end else begin
      imem_rvalid <= imem_req;
      imem_rdata  <= imem_word;
      dcnt        <= dmem_req ? dcnt + 1 : 0;
    end
  end
  assign dmem_rvalid = dmem_req && (dcnt == dlat - 1);

  logic [7:0] obs;
  assign obs = {state, imem_req, dmem_req, dmem_we, rf_wr_en, load_en};

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (obs !== 8'b000_00000) begin
      $display("FAIL reset_strobes obs=%b exp=%b", obs, 8'b000_00000);
      nerr++;
    end
    nvec++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      $display("FAIL reset_pc pc=%h addr=%h exp=0", pc, imem_addr);
      nerr++;
    end
    nvec++;
    if (instr !== 32'h0000_0013) begin
      $display("FAIL reset_instr got=%h exp=00000013", instr);
      nerr++;
    end
    nvec++;
    if (retire !== 32'h0 || illegal !== 1'b0) begin
      $display("FAIL reset_cnt_ill cnt=%h ill=%b exp=0/0", retire, illegal);
      nerr++;
    end
    nvec++;
    if (pc_w !== 32'hFFFF_FFFC) begin
      $display("FAIL reset_pc_param got=%h exp=fffffffc", pc_w);
      nerr++;
    end
  endtask

  task automatic test_addi();
    logic [7:0] exp [6] = '{8'b000_10000, 8'b001_00000, 8'b010_00000,
                            8'b011_00000, 8'b101_00010, 8'b000_10000};
    imem_word = 32'h0050_0093;
    dlat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL addi_cyc%0d obs=%b exp=%b", k + 1, obs, exp[k]);
        nerr++;
      end
    end
    nvec++;
    if (pc !== 32'd4 || imem_addr !== 32'd4) begin
      $display("FAIL addi_pc pc=%h addr=%h exp=4", pc, imem_addr);
      nerr++;
    end
    nvec++;
    if (retire !== 32'd1) begin
      $display("FAIL addi_retire got=%0d exp=1", retire);
      nerr++;
    end
    nvec++;
    if (instr !== 32'h0050_0093) begin
      $display("FAIL addi_instr got=%h exp=00500093", instr);
      nerr++;
    end
  endtask

  task automatic test_load();
    logic [7:0] exp [9] = '{8'b000_10000, 8'b001_00000, 8'b010_00000,
                            8'b011_00000, 8'b100_01001, 8'b100_01001,
                            8'b100_01001, 8'b101_00011, 8'b000_10000};
    imem_word = 32'h0000_A103;
    dlat = 3;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL load_cyc%0d obs=%b exp=%b", k + 1, obs, exp[k]);
        nerr++;
      end
    end
    nvec++;
    if (pc !== 32'd4 || retire !== 32'd1) begin
      $display("FAIL load_pc_cnt pc=%h cnt=%0d exp=4/1", pc, retire);
      nerr++;
    end
  endtask

  task automatic test_store();
    logic [7:0] exp [6] = '{8'b000_10000, 8'b001_00000, 8'b010_00000,
                            8'b011_00000, 8'b100_01100, 8'b000_10000};
    imem_word = 32'h0020_A023;
    dlat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL store_cyc%0d obs=%b exp=%b", k + 1, obs, exp[k]);
        nerr++;
      end
    end
    nvec++;
    if (pc !== 32'd4 || retire !== 32'd1) begin
      $display("FAIL store_pc_cnt pc=%h cnt=%0d exp=4/1", pc, retire);
      nerr++;
    end
  endtask

  task automatic test_x0_write();
    logic [7:0] exp [6] = '{8'b000_10000, 8'b001_00000, 8'b010_00000,
                            8'b011_00000, 8'b101_00000, 8'b000_10000};
    imem_word = 32'h0000_0033;
    dlat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL x0_cyc%0d obs=%b exp=%b", k + 1, obs, exp[k]);
        nerr++;
      end
    end
    nvec++;
    if (pc !== 32'd4 || retire !== 32'd1) begin
      $display("FAIL x0_pc_cnt pc=%h cnt=%0d exp=4/1", pc, retire);
      nerr++;
    end
  endtask

  task automatic test_illegal();
    logic [7:0] exp [4] = '{8'b000_10000, 8'b001_00000,
                            8'b010_00000, 8'b110_00000};
    imem_word = 32'h0000_006F;
    dlat = 1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL ill_cyc%0d obs=%b exp=%b", k + 1, obs, exp[k]);
        nerr++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      nvec++;
      if ({obs, illegal, pc, retire} !== {8'b110_00000, 1'b1, 64'h0}) begin
        $display("FAIL halt_cyc%0d obs=%b ill=%b pc=%h cnt=%0d exp=11000000/1/0/0",
                 k, obs, illegal, pc, retire);
        nerr++;
      end
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (illegal !== 1'b0 || state !== 3'd0) begin
      $display("FAIL ill_clear ill=%b state=%0d exp=0/0", illegal, state);
      nerr++;
    end
  endtask

  task automatic test_pc_wrap();
    imem_word = 32'h0050_0093;
    dlat = 1;
    do_reset();
    @(negedge clk);
    nvec++;
    if (imem_addr_w !== 32'hFFFF_FFFC || imem_req_w !== 1'b1) begin
      $display("FAIL wrap_fetch addr=%h req=%b exp=fffffffc/1",
               imem_addr_w, imem_req_w);
      nerr++;
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (pc_w !== 32'h0 || imem_addr_w !== 32'h0) begin
      $display("FAIL wrap_pc pc=%h addr=%h exp=0", pc_w, imem_addr_w);
      nerr++;
    end
    nvec++;
    if (retire_w !== 32'd1 || state_w !== 3'd0) begin
      $display("FAIL wrap_cnt cnt=%0d state=%0d exp=1/0", retire_w, state_w);
      nerr++;
    end
  endtask

  task automatic test_reset_in_mem();
    imem_word = 32'h0050_0093;
    dlat = 10;
    do_reset();
    repeat (5) @(negedge clk);
    imem_word = 32'h0000_A103;
    repeat (6) @(negedge clk);
    nvec++;
    if ({state, dmem_req, load_en, pc, retire} !== {3'd4, 2'b11, 32'd4, 32'd1}) begin
      $display("FAIL mem_pre state=%0d req=%b ld=%b pc=%h cnt=%0d exp=4/1/1/4/1",
               state, dmem_req, load_en, pc, retire);
      nerr++;
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (dmem_req !== 1'b0 || load_en !== 1'b0 || imem_req !== 1'b0) begin
      $display("FAIL mem_rst_req dreq=%b ld=%b ireq=%b exp=0/0/0",
               dmem_req, load_en, imem_req);
      nerr++;
    end
    nvec++;
    if ({state, pc, retire, instr} !== {3'd0, 32'd0, 32'd0, 32'h13}) begin
      $display("FAIL mem_rst_regs state=%0d pc=%h cnt=%0d instr=%h exp=0/0/0/13",
               state, pc, retire, instr);
      nerr++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (obs !== 8'b000_10000) begin
      $display("FAIL mem_restart1 obs=%b exp=%b", obs, 8'b000_10000);
      nerr++;
    end
    @(negedge clk);
    nvec++;
    if (obs !== 8'b001_00000) begin
      $display("FAIL mem_restart2 obs=%b exp=%b", obs, 8'b001_00000);
      nerr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_x0_write();
    test_illegal();
    test_pc_wrap();
    test_reset_in_mem();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
